// File: rtl/tdc_thermo_decoder.sv
// Thermometer-code TDC decoder: bubble-filters a registered delay-line snapshot on each hit,
// popcounts it into a fine code, tags it with a coarse count and queues it for readout.
module tdc_thermo_decoder #(
  parameter int TAPS       = 128,
  parameter int COARSE_W   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int FINE_W     = 8
) (
  input  logic                            iCLK,
  input  logic                            iRESETn,
  input  logic [TAPS-1:0]                 iTAP,
  input  logic                            iHIT,
  input  logic                            iREADY,
  output logic                            oVALID,
  output logic [COARSE_W+FINE_W:0]        oDATA,
  output logic [$clog2(FIFO_DEPTH):0]     oLEVEL,
  input  logic                            iCLR,
  output logic                            oOVERFLOW,
  output logic [7:0]                      oDROP_CNT
);

  localparam int GROUPS = TAPS / 8;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int DW     = 1 + COARSE_W + FINE_W;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [3:0] pop8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  logic [1:0]          rst_sync_r;
  logic                rst_int_n;
  logic [COARSE_W-1:0] coarse_r;
  logic [TAPS+1:0]     tap_ext_s;
  logic [TAPS-1:0]     filtered_s;

  logic                s1_valid_r;
  logic [TAPS-1:0]     s1_word_r;
  logic [COARSE_W-1:0] s1_coarse_r;
  logic                s2_valid_r;
  logic [3:0]          s2_part_r [GROUPS];
  logic [COARSE_W-1:0] s2_coarse_r;
  logic [FINE_W-1:0]   sum_s;
  logic                range_s;
  logic                s3_valid_r;
  logic [FINE_W-1:0]   s3_fine_r;
  logic                s3_range_r;
  logic [COARSE_W-1:0] s3_coarse_r;

  logic [DW-1:0]       mem_r [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_r;
  logic [AW-1:0]       rd_ptr_r;
  logic [AW:0]         count_r;
  logic [AW:0]         count_next_s;
  logic                valid_r;
  logic                overflow_r;
  logic [7:0]          drop_cnt_r;
  logic                pop_s;
  logic                full_s;
  logic                push_ok_s;
  logic                drop_s;

  // Reset asserts immediately and is released two edges after iRESETn rises
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) rst_sync_r <= 2'b00;
    else          rst_sync_r <= {rst_sync_r[0], 1'b1};
  end
  assign rst_int_n = rst_sync_r[1];

  // Free-running coarse time base
  always_ff @(posedge iCLK or negedge rst_int_n) begin
    if (!rst_int_n) coarse_r <= {COARSE_W{1'b0}};
    else            coarse_r <= coarse_r + COARSE_W'(1);
  end

  // Line ends are pinned: before tap 0 the edge has passed, beyond the last tap it has not
  assign tap_ext_s = {1'b0, iTAP, 1'b1};

  // Three-tap majority vote removes single-bit bubbles
  always_comb begin
    filtered_s = {TAPS{1'b0}};
    for (int i = 0; i < TAPS; i++) begin
      filtered_s[i] = maj3(tap_ext_s[i], tap_ext_s[i+1], tap_ext_s[i+2]);
    end
  end

  // Stage 1: capture filtered word and timestamp
  always_ff @(posedge iCLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      s1_valid_r  <= 1'b0;
      s1_word_r   <= {TAPS{1'b0}};
      s1_coarse_r <= {COARSE_W{1'b0}};
    end else begin
      s1_valid_r <= iHIT;
      if (iHIT) begin
        s1_word_r   <= filtered_s;
        s1_coarse_r <= coarse_r;
      end
    end
  end

  // Stage 2: per-byte popcounts
  always_ff @(posedge iCLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      s2_valid_r  <= 1'b0;
      s2_coarse_r <= {COARSE_W{1'b0}};
      for (int g = 0; g < GROUPS; g++) s2_part_r[g] <= 4'd0;
    end else begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_coarse_r <= s1_coarse_r;
        for (int g = 0; g < GROUPS; g++) s2_part_r[g] <= pop8(s1_word_r[g*8 +: 8]);
      end
    end
  end

  // Fine code sum and out-of-line detection
  always_comb begin
    sum_s = {FINE_W{1'b0}};
    for (int g = 0; g < GROUPS; g++) begin
      sum_s = sum_s + FINE_W'(s2_part_r[g]);
    end
    range_s = (sum_s == {FINE_W{1'b0}}) | (sum_s == FINE_W'(TAPS));
  end

  // Stage 3: completed timestamp ready for the FIFO
  always_ff @(posedge iCLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      s3_valid_r  <= 1'b0;
      s3_fine_r   <= {FINE_W{1'b0}};
      s3_range_r  <= 1'b0;
      s3_coarse_r <= {COARSE_W{1'b0}};
    end else begin
      s3_valid_r <= s2_valid_r;
      if (s2_valid_r) begin
        s3_fine_r   <= sum_s;
        s3_range_r  <= range_s;
        s3_coarse_r <= s2_coarse_r;
      end
    end
  end

  // A full FIFO still accepts a push when the head leaves on the same edge
  assign full_s    = (count_r == (AW+1)'(FIFO_DEPTH));
  assign pop_s     = valid_r & iREADY;
  assign push_ok_s = s3_valid_r & (~full_s | pop_s);
  assign drop_s    = s3_valid_r & full_s & ~pop_s;

  // Next occupancy
  always_comb begin
    count_next_s = count_r;
    case ({push_ok_s, pop_s})
      2'b10:   count_next_s = count_r + (AW+1)'(1);
      2'b01:   count_next_s = count_r - (AW+1)'(1);
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage and pointers
  always_ff @(posedge iCLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      for (int e = 0; e < FIFO_DEPTH; e++) mem_r[e] <= {DW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= {s3_range_r, s3_coarse_r, s3_fine_r};
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
    end
  end

  // Occupancy and valid flag
  always_ff @(posedge iCLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      count_r <= {(AW+1){1'b0}};
      valid_r <= 1'b0;
    end else begin
      count_r <= count_next_s;
      valid_r <= (count_next_s != {(AW+1){1'b0}});
    end
  end

  // Drop bookkeeping; a drop on the clearing edge takes priority
  always_ff @(posedge iCLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= 8'd0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (iCLR)                    drop_cnt_r <= 8'd1;
      else if (drop_cnt_r != 8'hFF) drop_cnt_r <= drop_cnt_r + 8'd1;
    end else if (iCLR) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= 8'd0;
    end
  end

  assign oVALID    = valid_r;
  assign oLEVEL    = count_r;
  assign oDATA     = mem_r[rd_ptr_r];
  assign oOVERFLOW = overflow_r;
  assign oDROP_CNT = drop_cnt_r;

endmodule

// File: tb/tb_tdc_thermo_decoder.sv
// Bench for tdc_thermo_decoder: directed scenarios plus random traffic against a
// queue-based reference model of timestamps, FIFO occupancy and drop accounting.
module tb_tdc_thermo_decoder;

  localparam int TAPS  = 128;
  localparam int DEPTH = 8;

  logic         iCLK;
  logic         iRESETn;
  logic [127:0] iTAP;
  logic         iHIT;
  logic         iREADY;
  logic         iCLR;
  logic         oVALID;
  logic [24:0]  oDATA;
  logic [3:0]   oLEVEL;
  logic         oOVERFLOW;
  logic [7:0]   oDROP_CNT;

  tdc_thermo_decoder dut (
    .iCLK(iCLK), .iRESETn(iRESETn), .iTAP(iTAP), .iHIT(iHIT), .iREADY(iREADY),
    .oVALID(oVALID), .oDATA(oDATA), .oLEVEL(oLEVEL), .iCLR(iCLR),
    .oOVERFLOW(oOVERFLOW), .oDROP_CNT(oDROP_CNT)
  );

  typedef struct { logic [24:0] d; longint due; } pend_t;

  pend_t        pend_q[$];
  logic [24:0]  fifo_q[$];
  longint       cyc;
  int           rel_cnt;
  logic         ovf_m;
  int           drop_m;
  int           n_checks;
  int           n_fail;
  logic [127:0] t;
  int           c0;

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] ones(input int n);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [127:0] rand_thermo();
    logic [127:0] v;
    v = ones($urandom_range(0, 128));
    if ($urandom % 3 == 0) v[$urandom % 128] = ~v[$urandom % 128];
    if ($urandom % 5 == 0) v[$urandom % 128] = 1'b1;
    if ($urandom % 16 == 0) v = {$urandom, $urandom, $urandom, $urandom};
    return v;
  endfunction

  // Fine code: count of taps whose 3-neighbourhood majority is 1, line ends pinned 1 / 0
  function automatic int fine_of(input logic [127:0] tv);
    int n;
    n = 0;
    for (int i = 0; i < TAPS; i++) begin
      int a, b, c;
      if (i == 0) a = 1; else a = int'(tv[i-1]);
      b = int'(tv[i]);
      if (i == TAPS - 1) c = 0; else c = int'(tv[i+1]);
      if (a + b + c >= 2) n++;
    end
    return n;
  endfunction

  function automatic logic [24:0] ref_entry(input logic [127:0] tv, input int coarse);
    int   f;
    logic rng;
    f   = fine_of(tv);
    rng = (f == 0) || (f == TAPS);
    return {rng, coarse[15:0], f[7:0]};
  endfunction

  // Coarse value the counter holds before the coming edge (it starts on the third edge after release)
  function automatic int coarse_next();
    return (rel_cnt >= 2) ? ((rel_cnt - 2) % 65536) : 0;
  endfunction

  task automatic model_clear();
    pend_q.delete();
    fifo_q.delete();
    ovf_m   = 1'b0;
    drop_m  = 0;
    rel_cnt = 0;
  endtask

  task automatic model_edge();
    logic  pop, push, dropped;
    pend_t p;
    cyc++;
    if (!iRESETn) begin
      model_clear();
      return;
    end
    if (rel_cnt >= 2) begin
      pop     = (fifo_q.size() > 0) && iREADY;
      push    = (pend_q.size() > 0) && (pend_q[0].due == cyc);
      dropped = 1'b0;
      if (pop) fifo_q.delete(0);
      if (push) begin
        p = pend_q.pop_front();
        if (fifo_q.size() < DEPTH) fifo_q.push_back(p.d);
        else dropped = 1'b1;
      end
      if (dropped) begin
        ovf_m  = 1'b1;
        drop_m = iCLR ? 1 : ((drop_m < 255) ? drop_m + 1 : 255);
      end else if (iCLR) begin
        ovf_m  = 1'b0;
        drop_m = 0;
      end
      if (iHIT) pend_q.push_back('{ref_entry(iTAP, coarse_next()), cyc + 3});
    end
    rel_cnt++;
  endtask

  task automatic check_outputs();
    check_eq("valid", oVALID, fifo_q.size() > 0);
    check_eq("level", oLEVEL, fifo_q.size());
    if (fifo_q.size() > 0) check_eq("data", oDATA, fifo_q[0]);
    check_eq("overflow", oOVERFLOW, ovf_m);
    check_eq("drop_cnt", oDROP_CNT, drop_m);
  endtask

  task automatic tick();
    @(posedge iCLK);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic hit(input logic [127:0] tv);
    iHIT = 1'b1;
    iTAP = tv;
    tick();
    iHIT = 1'b0;
    iTAP = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic pop_one();
    iREADY = 1'b1;
    tick();
    iREADY = 1'b0;
  endtask

  task automatic do_reset();
    iRESETn = 1'b0;
    #1;
    model_clear();
    check_eq("rst_valid", oVALID, 1'b0);
    check_eq("rst_level", oLEVEL, 4'd0);
    check_eq("rst_data", oDATA, 25'd0);
    check_eq("rst_overflow", oOVERFLOW, 1'b0);
    check_eq("rst_drop_cnt", oDROP_CNT, 8'd0);
    repeat (2) tick();
    iRESETn = 1'b1;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    iRESETn = 1'b1; iHIT = 1'b0; iREADY = 1'b0; iCLR = 1'b0; iTAP = '0;
    model_clear();
    #2;
    do_reset();

    // First event at coarse 5, 40 taps set
    while (coarse_next() != 5) tick();
    hit(ones(40));
    repeat (3) tick();
    check_eq("t1_valid", oVALID, 1'b1);
    check_eq("t1_data", oDATA, {1'b0, 16'd5, 8'd40});
    check_eq("t1_level", oLEVEL, 4'd1);
    pop_one();

    // Bubble and out-of-range words
    t = ones(40); t[20] = 1'b0; t[45] = 1'b1;
    hit(t);
    t = '1; hit(t);
    t = '0; hit(t);
    repeat (3) tick();
    check_eq("bub_fine", oDATA[7:0], 8'd40);
    check_eq("bub_range", oDATA[24], 1'b0);
    pop_one();
    check_eq("all1_fine", oDATA[7:0], 8'd128);
    check_eq("all1_range", oDATA[24], 1'b1);
    pop_one();
    check_eq("all0_fine", oDATA[7:0], 8'd0);
    check_eq("all0_range", oDATA[24], 1'b1);
    pop_one();

    // Ten hits into a stalled FIFO
    c0 = coarse_next();
    repeat (10) hit(rand_thermo());
    repeat (3) tick();
    check_eq("ovf_level", oLEVEL, 4'd8);
    check_eq("ovf_flag", oOVERFLOW, 1'b1);
    check_eq("ovf_drops", oDROP_CNT, 8'd2);
    for (int i = 0; i < 8; i++) begin
      check_eq("drain_coarse", oDATA[23:8], (c0 + i) % 65536);
      pop_one();
    end
    check_eq("drain_empty", oVALID, 1'b0);
    iCLR = 1'b1; tick(); iCLR = 1'b0;
    check_eq("clr_flag", oOVERFLOW, 1'b0);
    check_eq("clr_cnt", oDROP_CNT, 8'd0);

    // Full FIFO, push coincides with pop
    repeat (8) hit(rand_thermo());
    repeat (3) tick();
    check_eq("full_level", oLEVEL, 4'd8);
    hit(rand_thermo());
    tick(); tick();
    iREADY = 1'b1; tick(); iREADY = 1'b0;
    check_eq("fullpop_level", oLEVEL, 4'd8);
    check_eq("fullpop_drops", oDROP_CNT, 8'd0);

    // Two drops, then a drop on the clearing edge
    hit(rand_thermo()); hit(rand_thermo());
    repeat (3) tick();
    check_eq("drop2_cnt", oDROP_CNT, 8'd2);
    hit(rand_thermo());
    tick(); tick();
    iCLR = 1'b1; tick(); iCLR = 1'b0;
    check_eq("clrdrop_flag", oOVERFLOW, 1'b1);
    check_eq("clrdrop_cnt", oDROP_CNT, 8'd1);

    // Saturation of the drop counter
    repeat (260) hit(rand_thermo());
    repeat (3) tick();
    check_eq("sat_cnt", oDROP_CNT, 8'd255);
    iCLR = 1'b1; tick(); iCLR = 1'b0;
    iREADY = 1'b1; repeat (10) tick(); iREADY = 1'b0;
    check_eq("sat_drained", oVALID, 1'b0);

    // Random traffic
    repeat (1500) begin
      iHIT   = ($urandom % 2) == 0;
      iTAP   = rand_thermo();
      iREADY = ($urandom % 4) != 0;
      iCLR   = ($urandom % 32) == 0;
      tick();
    end
    iHIT = 1'b0; iCLR = 1'b0; iREADY = 1'b1;
    repeat (6) tick();
    iREADY = 1'b0;

    // Coarse wrap
    while (coarse_next() != 65535) tick();
    hit(rand_thermo()); hit(rand_thermo());
    repeat (3) tick();
    check_eq("wrap_level", oLEVEL, 4'd2);
    check_eq("wrap_hi", oDATA[23:8], 16'hFFFF);
    pop_one();
    check_eq("wrap_lo", oDATA[23:8], 16'h0000);
    pop_one();

    // Reset with entries queued and three events in flight
    hit(rand_thermo()); hit(rand_thermo());
    repeat (3) tick();
    hit(rand_thermo()); hit(rand_thermo()); hit(rand_thermo());
    do_reset();
    repeat (12) begin
      tick();
      check_eq("post_rst_valid", oVALID, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
